// File: rtl/lcd_text_refresh_if.sv
// Character-LCD pin bundle (HD44780-class parallel bus, write-only use).
// The driver owns the master side; a panel model or pin wrapper takes the slave side.
interface lcd_text_refresh_if;
    logic       LCD_ON;
    logic       LCD_BLON;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;
    logic [7:0] LCD_DATA;

    modport master (output LCD_ON, LCD_BLON, LCD_RW, LCD_EN, LCD_RS, LCD_DATA);
    modport slave  (input  LCD_ON, LCD_BLON, LCD_RW, LCD_EN, LCD_RS, LCD_DATA);
endinterface

// File: rtl/lcd_text_refresh.sv
// lcd_text_refresh: HD44780-class text-panel driver for ROWS x COLS displays.
// Sequence: power-on wait -> init commands -> frames of row-address + character writes.
// Each write holds RS/DATA, idles EN for SETUP_CYC, pulses EN for EN_CYC, then waits.
// Optional macro LCD_TEXT_HEX_EN adds a HEX input that renders each low nibble as ASCII hex.
module lcd_text_refresh #(
    parameter int ROWS      = 2,
    parameter int COLS      = 16,
    parameter int PWR_DLY   = 2000000,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 16,
    parameter int CMD_DLY   = 2500,
    parameter int CLR_DLY   = 100000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [ROWS*COLS*8-1:0] TEXT,
    input  logic                   UPDATE,
    input  logic                   AUTO_REFRESH,
`ifdef LCD_TEXT_HEX_EN
    input  logic                   HEX,
`endif
    output logic                   BUSY,
    output logic                   FRAME_DONE,
    lcd_text_refresh_if.master     lcd
);

    localparam int TW   = ROWS * COLS * 8;
    localparam int MAXD = (PWR_DLY > CLR_DLY) ? PWR_DLY : CLR_DLY;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int XW   = $clog2(COLS + 1);

    localparam logic [CW-1:0] PWR_LAST   = CW'(PWR_DLY - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_DLY - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_DLY - 1);
    localparam logic [XW-1:0] COL_LAST   = XW'(COLS);
    localparam logic [1:0]    ROW_LAST   = 2'(ROWS - 1);

    typedef enum logic [2:0] {S_PWR, S_SETUP, S_EN, S_WAIT, S_DONE, S_IDLE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx, wait_last;
    logic            init_mode, init_nx;
    logic [1:0]      step, step_nx;
    logic [1:0]      row, row_nx;
    logic [XW-1:0]   cidx, cidx_nx;          // 0 = row address command, 1..COLS = characters
    logic            pending, pending_nx;
    logic            load_snap, shift_snap, writing;
    logic [TW-1:0]   snap;                   // current character is always the top byte
`ifdef LCD_TEXT_HEX_EN
    logic            hex_mode;
`endif

    function automatic logic [7:0] init_cmd(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'(COLS);
            default: return 8'h40 + 8'(COLS);
        endcase
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [7:0] b);
        logic [7:0] n;
        n = {4'h0, b[3:0]};
        return (n < 8'd10) ? 8'h30 + n : 8'h37 + n;
    endfunction

    // Next-state, write sequencing and request bookkeeping.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 1'b1;
        init_nx    = init_mode;
        step_nx    = step;
        row_nx     = row;
        cidx_nx    = cidx;
        pending_nx = pending | UPDATE;
        load_snap  = 1'b0;
        shift_snap = 1'b0;
        wait_last  = (init_mode && step == 2'd2) ? CLR_LAST : CMD_LAST;
        case (state)
            S_PWR: begin
                if (cnt == PWR_LAST) begin
                    state_nx = S_SETUP;
                    cnt_nx   = '0;
                    init_nx  = 1'b1;
                    step_nx  = 2'd0;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nx = S_EN;
                    cnt_nx   = '0;
                end
            end
            S_EN: begin
                if (cnt == EN_LAST) begin
                    state_nx = S_WAIT;
                    cnt_nx   = '0;
                end
            end
            S_WAIT: begin
                if (cnt == wait_last) begin
                    cnt_nx   = '0;
                    state_nx = S_SETUP;
                    if (init_mode) begin
                        if (step == 2'd3) begin
                            // Init complete: first frame runs without a request.
                            init_nx   = 1'b0;
                            load_snap = 1'b1;
                            row_nx    = 2'd0;
                            cidx_nx   = '0;
                        end else begin
                            step_nx = step + 2'd1;
                        end
                    end else begin
                        shift_snap = (cidx != '0);
                        if (cidx == COL_LAST) begin
                            cidx_nx = '0;
                            if (row == ROW_LAST) state_nx = S_DONE;
                            else                 row_nx   = row + 2'd1;
                        end else begin
                            cidx_nx = cidx + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                // An UPDATE arriving on this very cycle still earns one more frame.
                cnt_nx     = '0;
                pending_nx = 1'b0;
                if (AUTO_REFRESH || pending || UPDATE) begin
                    state_nx  = S_SETUP;
                    load_snap = 1'b1;
                    row_nx    = 2'd0;
                    cidx_nx   = '0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_IDLE: begin
                cnt_nx     = '0;
                pending_nx = 1'b0;
                if (UPDATE || AUTO_REFRESH) begin
                    state_nx  = S_SETUP;
                    load_snap = 1'b1;
                    row_nx    = 2'd0;
                    cidx_nx   = '0;
                end
            end
            default: begin
                state_nx = S_PWR;
                cnt_nx   = '0;
            end
        endcase
    end

    // Control state register with synchronous reset back to the power-on wait.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_PWR;
            cnt       <= '0;
            init_mode <= 1'b1;
            step      <= 2'd0;
            row       <= 2'd0;
            cidx      <= '0;
            pending   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            init_mode <= init_nx;
            step      <= step_nx;
            row       <= row_nx;
            cidx      <= cidx_nx;
            pending   <= pending_nx;
        end
    end

    // Frame snapshot: captured at frame start, shifted one character per data write.
    always_ff @(posedge CLK) begin
        if (load_snap) begin
            snap     <= TEXT;
`ifdef LCD_TEXT_HEX_EN
            hex_mode <= HEX;
`endif
        end else if (shift_snap) begin
            snap <= {snap[TW-9:0], 8'h00};
        end
    end

    // Pin decode: RS/DATA stay fixed for the whole write, EN only in its pulse window.
    always_comb begin
        writing      = (state == S_SETUP) || (state == S_EN) || (state == S_WAIT);
        lcd.LCD_EN   = (state == S_EN);
        lcd.LCD_RS   = 1'b0;
        lcd.LCD_DATA = 8'h00;
        if (writing) begin
            if (init_mode) begin
                lcd.LCD_DATA = init_cmd(step);
            end else if (cidx == '0) begin
                lcd.LCD_DATA = 8'h80 | row_base(row);
            end else begin
                lcd.LCD_RS   = 1'b1;
`ifdef LCD_TEXT_HEX_EN
                lcd.LCD_DATA = hex_mode ? hex_ascii(snap[TW-1 -: 8]) : snap[TW-1 -: 8];
`else
                lcd.LCD_DATA = snap[TW-1 -: 8];
`endif
            end
        end
    end

    assign lcd.LCD_ON   = 1'b1;
    assign lcd.LCD_BLON = 1'b1;
    assign lcd.LCD_RW   = 1'b0;
    assign BUSY         = (state != S_IDLE);
    assign FRAME_DONE   = (state == S_DONE);

endmodule

// File: tb/tb_lcd_text_refresh.sv
// Self-checking bench for lcd_text_refresh: expected panel writes come from a
// frame-level model (command list + character table), compared cycle by cycle.
`timescale 1ns/1ps
module tb_lcd_text_refresh;
    localparam int ROWS = 2, COLS = 16, PWR_DLY = 10, SETUP_CYC = 1, EN_CYC = 2;
    localparam int CMD_DLY = 4, CLR_DLY = 8;
    localparam int N = ROWS * COLS;
    localparam int FRAME_PERIOD = ROWS * (COLS + 1) * (SETUP_CYC + EN_CYC + CMD_DLY) + 1;

    typedef logic [7:0] txt_t [N];
    typedef struct { logic rs; logic [7:0] data; int post; } wr_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*8-1:0] text = '0;
    logic           update = 1'b0;
    logic           auto_refresh = 1'b0;
`ifdef LCD_TEXT_HEX_EN
    logic           hex = 1'b0;
`endif
    logic           busy, frame_done;
    int             vectors = 0, miscompares = 0;
    int             cycle = 0;
    wr_t            exp_q[$];
    txt_t           cur_txt;

    lcd_text_refresh_if lcd();

    lcd_text_refresh #(
        .ROWS(ROWS), .COLS(COLS), .PWR_DLY(PWR_DLY), .SETUP_CYC(SETUP_CYC),
        .EN_CYC(EN_CYC), .CMD_DLY(CMD_DLY), .CLR_DLY(CLR_DLY)
    ) dut (
        .CLK(clk), .RST(rst), .TEXT(text), .UPDATE(update), .AUTO_REFRESH(auto_refresh),
`ifdef LCD_TEXT_HEX_EN
        .HEX(hex),
`endif
        .BUSY(busy), .FRAME_DONE(frame_done), .lcd(lcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*8-1:0] pack(input txt_t t);
        logic [N*8-1:0] v = '0;
        for (int i = 0; i < N; i++) v = {v[N*8-9:0], t[i]};
        return v;
    endfunction

    function automatic logic [7:0] shown(input logic [7:0] c, input bit hx);
        int n;
        n = c % 16;
        if (!hx) return c;
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    task automatic set_str(input string a, input string b);
        for (int i = 0; i < COLS; i++) begin
            cur_txt[i]        = a[i];
            cur_txt[COLS + i] = b[i];
        end
        text = pack(cur_txt);
    endtask

    task automatic set_rand(input int lo, input int hi);
        for (int i = 0; i < N; i++) cur_txt[i] = 8'($urandom_range(hi, lo));
        text = pack(cur_txt);
    endtask

    task automatic build_init();
        exp_q.delete();
        exp_q.push_back('{rs: 1'b0, data: 8'h38, post: CMD_DLY});
        exp_q.push_back('{rs: 1'b0, data: 8'h0C, post: CMD_DLY});
        exp_q.push_back('{rs: 1'b0, data: 8'h01, post: CLR_DLY});
        exp_q.push_back('{rs: 1'b0, data: 8'h06, post: CMD_DLY});
    endtask

    task automatic build_frame(input bit hx);
        int base[4];
        base = '{0, 'h40, COLS, 'h40 + COLS};
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back('{rs: 1'b0, data: 8'(8'h80 | base[r]), post: CMD_DLY});
            for (int c = 0; c < COLS; c++)
                exp_q.push_back('{rs: 1'b1, data: shown(cur_txt[r*COLS + c], hx), post: CMD_DLY});
        end
    endtask

    task automatic check_write(input wr_t w, input bit pulse, input string tag);
        int          total;
        logic [31:0] en_obs, en_exp;
        logic [8:0]  rsd_obs, rsd_exp;
        logic [1:0]  ctl_obs;
        total   = SETUP_CYC + EN_CYC + w.post;
        en_obs  = '0;
        en_exp  = '0;
        rsd_exp = {w.rs, w.data};
        rsd_obs = rsd_exp;
        ctl_obs = 2'b00;
        for (int k = 0; k < total; k++) begin
            en_obs[k] = lcd.LCD_EN;
            en_exp[k] = (k >= SETUP_CYC) && (k < SETUP_CYC + EN_CYC);
            if ({lcd.LCD_RS, lcd.LCD_DATA} !== rsd_exp && rsd_obs === rsd_exp)
                rsd_obs = {lcd.LCD_RS, lcd.LCD_DATA};
            if (busy !== 1'b1)       ctl_obs[1] = 1'b1;
            if (frame_done !== 1'b0) ctl_obs[0] = 1'b1;
            tick();
            if (pulse && k == 0) update = 1'b0;
        end
        chk({tag, " en_pattern"}, en_obs, en_exp);
        chk({tag, " rs_data"}, 32'(rsd_obs), 32'(rsd_exp));
        chk({tag, " busy_low/done_high"}, 32'(ctl_obs), 32'd0);
    endtask

    task automatic check_pwr(input string tag);
        int bad = 0;
        for (int k = 0; k < PWR_DLY; k++) begin
            if (lcd.LCD_EN !== 1'b0 || lcd.LCD_RS !== 1'b0 || lcd.LCD_DATA !== 8'h00 ||
                busy !== 1'b1 || frame_done !== 1'b0) bad++;
            tick();
        end
        chk({tag, " pwr_wait bad cycles"}, bad, 0);
    endtask

    task automatic check_init(input string tag);
        build_init();
        for (int i = 0; i < exp_q.size(); i++)
            check_write(exp_q[i], 1'b0, $sformatf("%s init%0d", tag, i));
    endtask

    task automatic check_frame(input bit hx, input bit disturb, input bit drop_auto, input string tag);
        txt_t xs;
        bit   p;
        build_frame(hx);
        for (int i = 0; i < exp_q.size(); i++) begin
            p = 1'b0;
            if (disturb && i == 5) begin
                for (int j = 0; j < N; j++) xs[j] = 8'h58;
                text = pack(xs);
            end
            if (disturb && (i == 8 || i == 20)) begin
                update = 1'b1;
                p = 1'b1;
            end
            if (drop_auto && i == 10) auto_refresh = 1'b0;
            check_write(exp_q[i], p, $sformatf("%s w%0d", tag, i));
        end
    endtask

    task automatic check_done(input string tag, output int at);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd1);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd1);
        chk({tag, " en_at_done"}, 32'(lcd.LCD_EN), 32'd0);
        at = cycle;
    endtask

    task automatic check_idle(input int n, input string tag);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if (busy !== 1'b0 || lcd.LCD_EN !== 1'b0 || frame_done !== 1'b0) bad++;
            tick();
        end
        chk({tag, " idle bad cycles"}, bad, 0);
    endtask

    initial begin
        int d1, d2, d3;

        // Reset and power-on sequence
        set_str("0123456789ABCDEF", "fedcba9876543210");
        tick();
        tick();
        rst = 1'b0;
        chk("reset en", 32'(lcd.LCD_EN), 32'd0);
        chk("reset rs", 32'(lcd.LCD_RS), 32'd0);
        chk("reset data", 32'(lcd.LCD_DATA), 32'd0);
        chk("reset busy", 32'(busy), 32'd1);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("const on/blon/rw", 32'({lcd.LCD_ON, lcd.LCD_BLON, lcd.LCD_RW}), 32'b110);
        check_pwr("boot");
        check_init("boot");

        // First frame runs unrequested; mid-frame text change and two UPDATE pulses
        check_frame(1'b0, 1'b1, 1'b0, "frame1");
        check_done("frame1", d1);
        tick();
        for (int i = 0; i < N; i++) cur_txt[i] = 8'h58;
        check_frame(1'b0, 1'b0, 1'b0, "extraX");
        check_done("extraX", d1);
        tick();
        check_idle(6, "after_extra");

        // UPDATE from idle with random text, then UPDATE on the FRAME_DONE cycle
        set_rand(32, 126);
        update = 1'b1;
        tick();
        update = 1'b0;
        check_frame(1'b0, 1'b0, 1'b0, "upd");
        check_done("upd", d1);
        set_rand(32, 126);
        update = 1'b1;
        tick();
        update = 1'b0;
        check_frame(1'b0, 1'b0, 1'b0, "upd_at_done");
        check_done("upd_at_done", d1);
        tick();
        check_idle(3, "after_upd");

        // Continuous refresh, dropped during the third frame
        set_rand(32, 126);
        auto_refresh = 1'b1;
        tick();
        check_frame(1'b0, 1'b0, 1'b0, "auto1");
        check_done("auto1", d1);
        set_rand(32, 126);
        tick();
        check_frame(1'b0, 1'b0, 1'b0, "auto2");
        check_done("auto2", d2);
        chk("auto period 1-2", d2 - d1, FRAME_PERIOD);
        set_rand(32, 126);
        tick();
        check_frame(1'b0, 1'b0, 1'b1, "auto3");
        check_done("auto3", d3);
        chk("auto period 2-3", d3 - d2, FRAME_PERIOD);
        tick();
        check_idle(4, "after_auto");

`ifdef LCD_TEXT_HEX_EN
        // Hex rendering of low nibbles
        set_rand(0, 255);
        cur_txt[0] = 8'h0A;
        cur_txt[1] = 8'h03;
        cur_txt[2] = 8'hF9;
        text = pack(cur_txt);
        hex = 1'b1;
        update = 1'b1;
        tick();
        update = 1'b0;
        hex = 1'b0;
        check_frame(1'b1, 1'b0, 1'b0, "hex");
        check_done("hex", d1);
        tick();
        check_idle(2, "after_hex");
`endif

        // Reset in the middle of a data write restarts everything
        set_rand(32, 126);
        update = 1'b1;
        tick();
        update = 1'b0;
        build_frame(1'b0);
        for (int i = 0; i < 3; i++) check_write(exp_q[i], 1'b0, $sformatf("prerst w%0d", i));
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst en", 32'(lcd.LCD_EN), 32'd0);
        chk("midrst data", 32'(lcd.LCD_DATA), 32'd0);
        chk("midrst rs", 32'(lcd.LCD_RS), 32'd0);
        chk("midrst busy", 32'(busy), 32'd1);
        chk("midrst frame_done", 32'(frame_done), 32'd0);
        check_pwr("restart");
        check_init("restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lcd_text_refresh.md
Name: lcd_text_refresh

Overview:
- Parametrised HD44780-class character-LCD driver for ROWSxCOLS text panels.
- Integrates enable-pulse timing, so no separate controller is needed.
- Runs power-on wait and init sequence, then writes a flat ASCII text bus to the panel.
- Snapshots text per frame, supports on-demand and continuous refresh, and reports BUSY/FRAME_DONE to the host logic.

Parameters:
ROWS, 2, display rows; legal 1..4
COLS, 16, characters per row; legal 8..40
PWR_DLY, 2000000, cycles of power-on wait before first command (40 ms at 50 MHz)
SETUP_CYC, 2, cycles RS/DATA stable with LCD_EN low before EN rises
EN_CYC, 16, cycles LCD_EN held high per write
CMD_DLY, 2500, post-write wait cycles for normal command/data (50 us)
CLR_DLY, 100000, post-write wait cycles after clear command 0x01 (2 ms)

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous active-high reset
TEXT  in  ROWS*COLS*8  characters; index i=r*COLS+c at TEXT[(ROWS*COLS-1-i)*8 +: 8] (row 0 col 0 in MSByte)
UPDATE  in  1  single-cycle request for one frame rewrite
AUTO_REFRESH  in  1  level; when high, frames repeat back-to-back
BUSY  out  1  high during init or frame write
FRAME_DONE  out  1  one-cycle pulse after last character of a frame
LCD_ON  out  1  constant 1
LCD_BLON  out  1  constant 1
LCD_RW  out  1  constant 0 (write only)
LCD_EN  out  1  enable strobe
LCD_RS  out  1  0=command, 1=data
LCD_DATA  out  8  data bus

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset values: LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, BUSY=1, FRAME_DONE=0, pending=0; FSM enters PWR_WAIT, counter=0.
- Reset asserted mid-operation: the next edge forces the reset values and restarts the sequence from PWR_WAIT, including full init.
- PWR_WAIT: count PWR_DLY cycles with all LCD outputs at reset values, then go to INIT.
- INIT: issue commands 0x38, 0x0C, 0x01, 0x06 in order (RS=0), then go to FRAME.
  - After 0x01 the post-write wait is CLR_DLY.
  - Every other write waits CMD_DLY.
- Write primitive, total SETUP_CYC+EN_CYC+(CMD_DLY or CLR_DLY) cycles:
  - RS/DATA are driven on entry and held constant for the whole write.
  - LCD_EN=0 for SETUP_CYC cycles, then 1 for EN_CYC cycles, then 0 for the post-write wait.
- FRAME:
  - On entry, register all of TEXT into an internal snapshot; later TEXT changes do not affect the frame in progress.
  - Per row r: write command 0x80|BASE(r), then COLS data writes (RS=1) of snapshot characters c=0..COLS-1.
  - BASE: 0x00, 0x40, COLS, 0x40+COLS for r=0..3.
  - Total writes per frame = ROWS*(COLS+1).
- After the last data write's post-wait: FRAME_DONE=1 for exactly one cycle.
  - If AUTO_REFRESH or pending is set: clear pending, start a new FRAME the next cycle; BUSY stays 1.
  - Otherwise go to IDLE with BUSY=0.
- IDLE: BUSY=0, LCD_EN=0. UPDATE=1 or AUTO_REFRESH=1 leads to FRAME next cycle, with BUSY=1 that cycle.
- UPDATE during PWR_WAIT/INIT/FRAME: set pending; multiple requests collapse to one extra frame.
- UPDATE in the same cycle FRAME_DONE is asserted counts as pending, so exactly one more frame follows.
- The first frame after init runs automatically, without UPDATE.
- Counters are sized $clog2(max(PWR_DLY, CLR_DLY)+1) bits; character index is sized $clog2(COLS+1) bits; no wrap occurs within legal parameters.

Optional Feature:
- Macro LCD_TEXT_HEX_EN.
- Defined:
  - Adds input HEX (1 bit), sampled with the snapshot at frame start.
  - When HEX=1, each character's low nibble n is sent as ASCII: n<10 -> 0x30+n, else 0x37+n (0xA -> 'A'=0x41).
  - Upper nibble is ignored.
  - When HEX=0, bytes pass unchanged.
- Not defined: the HEX port is absent and bytes always pass unchanged.

Test Plan:
- Bench parameters for all cases: ROWS=2, COLS=16, PWR_DLY=10, SETUP_CYC=1, EN_CYC=2, CMD_DLY=4, CLR_DLY=8.
- Reset release: LCD_EN stays 0 for 10 cycles; then writes 0x38, 0x0C, 0x01, 0x06 with RS=0. Each EN pulse is exactly 2 cycles; 0x01 is followed by 8 idle cycles, the others by 4.
- First frame with TEXT="0123456789ABCDEF" / "fedcba9876543210": writes 0x80, 16 data bytes, 0xC0, 16 data bytes; FRAME_DONE pulses once; BUSY then falls. The frame lasts 34 writes x 7 cycles.
- TEXT changed to all 'X' in mid-frame: remaining writes still carry the original characters. UPDATE pulsed twice during the frame: exactly one extra frame, with all 'X'.
- AUTO_REFRESH=1 held: FRAME_DONE pulses every 238 cycles plus the 1-cycle restart; BUSY never falls. Deasserting it makes BUSY fall after the current frame.
- RST asserted during a data write: next cycle LCD_EN=0, DATA=0, BUSY=1; the sequence restarts with a 10-cycle wait and 0x38.
- With LCD_TEXT_HEX_EN defined, HEX=1 and TEXT bytes 0x0A, 0x03, 0xF9: data writes are 0x41, 0x33, 0x39.
